noise_sched: RTL and testbench

Scheduler that owns the synth's 8-lane LFSR noise bank and shares its random byte stream between `NUM_REQ` voice requesters. It sequences the bank through load, warm-up and serve phases, and supports runtime reseeding. Round-robin arbitration hands each fresh byte to exactly one requester. It sits between the bank and the per-voice noise oscillators.

---
 rtl/noise_pkg.sv | 25 ++
 rtl/lfsr_bank8.sv | 35 +++
 rtl/noise_sched.sv | 117 +++++++++++
 tb/tb_noise_sched.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/noise_pkg.sv
// Shared constants for the noise scheduler: lane seeds, LFSR taps, byte tap
// position and the sequencing states.
package noise_pkg;

    localparam logic [30:0] SEED_BASE [0:7] = '{
        31'h1234_5678, 31'h2468_ACE1, 31'h3C6E_F372, 31'h0BAD_BEEF,
        31'h5A5A_5A5A, 31'h0123_4567, 31'h7654_321F, 31'h1F2E_3D4C
    };

    localparam int TAP_HI     = 30;
    localparam int TAP_LO     = 27;
    localparam int SAMPLE_BIT = 5;

    typedef enum logic [1:0] {
        S_LOAD,
        S_WARMUP,
        S_SERVE
    } state_t;

    // An all-zero lane would never leave zero, so it is replaced by 1.
    function automatic logic [30:0] lane_guard(input logic [30:0] v);
        return (v == '0) ? 31'h1 : v;
    endfunction

endpackage

// File: rtl/lfsr_bank8.sv
// Eight 31-bit Fibonacci LFSR lanes with zero-guarded loading; one byte is
// tapped per cycle from bit SAMPLE_BIT of each lane, lane 0 as MSB.
module lfsr_bank8
    import noise_pkg::*;
(
    input  logic        clk,
    input  logic        adv,
    input  logic        load,
    input  logic [30:0] seed,
    output logic [7:0]  byte_out
);

    logic [30:0] lane     [0:7];
    logic [30:0] lane_nxt [0:7];

    // byte_out is taken from the lane values that become current at the
    // coming edge, so a byte registered alongside a grant is the fresh one.
    always_comb begin
        byte_out = '0;
        for (int i = 0; i < 8; i++) begin
            lane_nxt[i] = lane[i];
            if (load)
                lane_nxt[i] = lane_guard(SEED_BASE[i] ^ seed);
            else if (adv)
                lane_nxt[i] = {lane[i][TAP_HI-1:0], lane[i][TAP_HI] ^ lane[i][TAP_LO]};
            byte_out[7-i] = lane_nxt[i][SAMPLE_BIT];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++)
            lane[i] <= lane_nxt[i];
    end

endmodule

// File: rtl/noise_sched.sv
// Sequences the LFSR bank (load, warm-up, serve) and hands each fresh byte to
// one requester round-robin. Optional stall counter: NOISE_SCHED_STALL_CNT_EN.
//
// state    | meaning
// S_LOAD   | lanes just loaded; warm-up timer armed
// S_WARMUP | bank free-runs until the warm-up timer expires
// S_SERVE  | bank free-runs; round-robin grants enabled
module noise_sched
    import noise_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WARMUP  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [7:0]         rnd_out,
    output logic               rnd_valid,
    input  logic               seed_load,
    input  logic [30:0]        seed,
    output logic               busy
`ifdef NOISE_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(WARMUP + 1);

    state_t             state, state_nxt;
    logic [CW-1:0]      wcnt, wcnt_nxt;
    logic [IW-1:0]      last, win, cand;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic               found;
    logic [7:0]         bank_byte;

    // Reset reuses the bank load path with a zero seed; the bank otherwise
    // free-runs in every state, the LOAD cycle included.
    lfsr_bank8 u_bank (
        .clk      (clk),
        .adv      (1'b1),
        .load     (rst | seed_load),
        .seed     (rst ? 31'h0 : seed),
        .byte_out (bank_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_LOAD;
            wcnt    <= '0;
            gnt     <= '0;
            rnd_out <= '0;
            last    <= IW'(NUM_REQ - 1);
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            gnt   <= gnt_nxt;
            if (|gnt_nxt) begin
                rnd_out <= bank_byte;
                last    <= win;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        gnt_nxt   = '0;
        win       = last;
        cand      = last;
        found     = 1'b0;
        case (state)
            S_LOAD: begin
                wcnt_nxt  = CW'(WARMUP - 1);
                state_nxt = S_WARMUP;
            end
            S_WARMUP: begin
                if (wcnt == '0)
                    state_nxt = S_SERVE;
                else
                    wcnt_nxt = wcnt - CW'(1);
            end
            S_SERVE: begin
                // The previous winner is masked via the registered gnt.
                for (int i = 1; i <= NUM_REQ; i++) begin
                    cand = IW'((int'(last) + i) % NUM_REQ);
                    if (!found && req[cand] && !gnt[cand]) begin
                        found = 1'b1;
                        win   = cand;
                    end
                end
                if (found)
                    gnt_nxt[win] = 1'b1;
            end
            default: state_nxt = S_LOAD;
        endcase
        if (seed_load) begin
            state_nxt = S_LOAD;
            gnt_nxt   = '0;
        end
    end

    assign busy      = (state != S_SERVE);
    assign rnd_valid = |gnt;

`ifdef NOISE_SCHED_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (|req && !(|gnt) && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_noise_sched.sv
// Randomised and directed bench for noise_sched against a cycle-level
// behavioural model of the bank, the phase timing and the round-robin rule.
module tb_noise_sched;
    import noise_pkg::*;

    localparam int NR = 4;
    localparam int WU = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req;
    logic [NR-1:0] gnt;
    logic [7:0]    rnd_out;
    logic          rnd_valid;
    logic          seed_load;
    logic [30:0]   seed;
    logic          busy;
`ifdef NOISE_SCHED_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    noise_sched #(.NUM_REQ(NR), .WARMUP(WU)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .rnd_out   (rnd_out),
        .rnd_valid (rnd_valid),
        .seed_load (seed_load),
        .seed      (seed),
        .busy      (busy)
`ifdef NOISE_SCHED_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [30:0]   m_lane [8];
    int            m_since;
    int            m_last;
    logic [NR-1:0] m_gnt;
    logic [7:0]    m_rnd;
    logic [15:0]   m_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [30:0] step_lane(input logic [30:0] v);
        return {v[29:0], v[30] ^ v[27]};
    endfunction

    function automatic logic [7:0] model_byte();
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = m_lane[i][5];
        return b;
    endfunction

    function automatic logic [7:0] base_byte_after(input int n);
        logic [30:0] l [8];
        logic [7:0]  b;
        for (int i = 0; i < 8; i++) begin
            l[i] = SEED_BASE[i];
            for (int k = 0; k < n; k++) l[i] = step_lane(l[i]);
            b[7-i] = l[i][5];
        end
        return b;
    endfunction

    // One clock edge of the reference behaviour, from the inputs at the edge.
    task automatic model_edge();
        logic [NR-1:0] prev;
        logic          serving;
        int            c;
        if (rst) begin
            for (int i = 0; i < 8; i++)
                m_lane[i] = (SEED_BASE[i] == 0) ? 31'h1 : SEED_BASE[i];
            m_since = 0;
            m_last  = NR - 1;
            m_gnt   = '0;
            m_rnd   = '0;
            m_stall = '0;
        end else begin
            prev    = m_gnt;
            serving = (m_since == WU + 1);
            if (req != 0 && prev == 0 && m_stall != 16'hFFFF) m_stall++;
            if (seed_load) begin
                for (int i = 0; i < 8; i++)
                    m_lane[i] = ((SEED_BASE[i] ^ seed) == 0) ? 31'h1 : (SEED_BASE[i] ^ seed);
                m_since = 0;
                m_gnt   = '0;
            end else begin
                for (int i = 0; i < 8; i++) m_lane[i] = step_lane(m_lane[i]);
                if (m_since < WU + 1) m_since++;
                m_gnt = '0;
                if (serving) begin
                    for (int k = 1; k <= NR; k++) begin
                        c = (m_last + k) % NR;
                        if (m_gnt == 0 && req[c] && !prev[c]) begin
                            m_gnt  = NR'(1 << c);
                            m_last = c;
                        end
                    end
                end
                if (m_gnt != 0) m_rnd = model_byte();
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("gnt", 32'(gnt), 32'(m_gnt));
        chk("rnd_valid", 32'(rnd_valid), 32'(m_gnt != 0));
        chk("rnd_out", 32'(rnd_out), 32'(m_rnd));
        chk("busy", 32'(busy), 32'(m_since < WU + 1));
`ifdef NOISE_SCHED_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    endtask

    task automatic do_reset(input logic [NR-1:0] r);
        rst = 1'b1; req = r; seed_load = 1'b0; seed = '0;
        step();
        step();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_rnd", 32'(rnd_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);
        rst = 1'b0;
    endtask

    initial begin
        int ngnt, nbusy, bound;
        logic seen;
        logic [NR-1:0] exp_rr [5];
        exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // reset release with a single held requester
        do_reset(4'b0001);
        for (int e = 1; e <= 6; e++) begin
            step();
            if (e == WU)     chk("busy_before_fall", 32'(busy), 32'h1);
            if (e == WU + 1) begin
                chk("busy_fall", 32'(busy), 32'h0);
                chk("no_early_gnt", 32'(gnt), 32'h0);
            end
            if (e == WU + 2) begin
                chk("first_gnt", 32'(gnt), 32'b0001);
                chk("first_byte", 32'(rnd_out), 32'(base_byte_after(6)));
            end
        end

        // round robin with all requesters held
        do_reset(4'b1111);
        for (int e = 1; e <= WU + 1; e++) step();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_seq", 32'(gnt), 32'(exp_rr[k]));
        end

        // lone requester gets every other cycle
        req  = 4'b0100;
        ngnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (gnt != 0) ngnt++;
        end
        chk("lone_count", 32'(ngnt), 32'd5);

        // reseed with zero seed mid-serve
        req = 4'b0011; seed_load = 1'b1; seed = 31'h0;
        step();
        chk("reseed_no_gnt", 32'(gnt), 32'h0);
        seed_load = 1'b0;
        nbusy = busy ? 1 : 0;
        seen  = 1'b0;
        bound = 0;
        while (!seen && bound < 20) begin
            step();
            bound++;
            if (gnt != 0) begin
                seen = 1'b1;
                chk("resume_gnt", 32'(gnt), 32'b0001);
            end else if (busy) nbusy++;
        end
        chk("reseed_served", 32'(seen), 32'h1);
        chk("reseed_busy_cycles", 32'(nbusy), 32'(WU + 1));

        // zero-guard: seed equal to lane 3's base seed
        seed_load = 1'b1; seed = SEED_BASE[3];
        step();
        chk("guard_lane3", 32'(dut.u_bank.lane[3]), 32'h1);
        seed_load = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            req = NR'($urandom_range(0, (1 << NR) - 1));
            step();
        end
        for (int i = 0; i < 8; i++)
            chk("lane_nonzero", 32'(dut.u_bank.lane[i] != 0), 32'h1);

        // random traffic with occasional reseeds and resets
        for (int k = 0; k < 3000; k++) begin
            req       = NR'($urandom_range(0, (1 << NR) - 1));
            seed_load = ($urandom_range(0, 99) < 2);
            seed      = 31'($urandom);
            rst       = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0; seed_load = 1'b0;

`ifdef NOISE_SCHED_STALL_CNT_EN
        do_reset(4'b1000);
        chk("stall_rst", 32'(stall_cnt), 32'h0);
        for (int e = 1; e <= WU + 2; e++) step();
        chk("stall_first_gnt", 32'(gnt), 32'b1000);
        chk("stall_at_gnt", 32'(stall_cnt), 32'd6);
        seed_load = 1'b1;
        for (int k = 0; k < 65540; k++) step();
        chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
        seed_load = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
